// File: rtl/div_unit_pkg.sv
// Shared types and helpers for the EX-stage divider (div_unit, div_step).
package div_unit_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [31:0] abs_if(input logic neg, input logic [31:0] v);
    return neg ? neg32(v) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division iteration on the {rem, quo} accumulator.
module div_step (
  input  logic [64:0] acc_in,
  input  logic [31:0] divisor,
  output logic [64:0] acc_out
);

  logic [65:0] shifted;
  logic [33:0] trial;

  // Trial is one bit wider than the remainder so its MSB is a clean sign bit.
  always_comb begin
    shifted = {acc_in, 1'b0};
    trial   = shifted[65:32] - {2'b00, divisor};
    if (!trial[33]) begin
      acc_out = {trial[32:0], shifted[31:1], 1'b1};
    end else begin
      acc_out = shifted[64:0];
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit DIV/DIVU unit. Define DIV_ZERO_EARLY_OUT_EN to let
// divide-by-zero finish through the BYZERO shortcut instead of the 32-step loop.
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic [31:0] div_opdata1,
  input  logic [31:0] div_opdata2,
  input  logic        div_annul,
  output logic [63:0] div_result,
  output logic        div_ready,
  output logic        stallreq_for_div
);

  div_state_e  state, next_state;
  logic [5:0]  cnt;
  logic [64:0] acc;
  logic [31:0] divisor_mag;
  logic        sign_dividend;
  logic        sign_divisor;
  logic [64:0] step_out;
  logic [64:0] acc_final;
  logic        accept;

  assign accept           = div_start && !div_annul;
  assign stallreq_for_div = div_start & ~div_ready;

  div_step u_step (
    .acc_in  (acc),
    .divisor (divisor_mag),
    .acc_out (step_out)
  );

  // Last iteration folds in sign correction: quotient by sign mismatch, remainder follows dividend.
  always_comb begin
    acc_final = {1'b0,
                 abs_if(sign_dividend, step_out[63:32]),
                 abs_if(sign_dividend ^ sign_divisor, step_out[31:0])};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DivFree;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      DivFree: begin
        if (accept) begin
`ifdef DIV_ZERO_EARLY_OUT_EN
          next_state = (div_opdata2 == 32'd0) ? DivByZero : DivOn;
`else
          next_state = DivOn;
`endif
        end else begin
          next_state = DivFree;
        end
      end
      DivByZero: begin
        next_state = div_annul ? DivFree : DivEnd;
      end
      DivOn: begin
        if (div_annul) begin
          next_state = DivFree;
        end else if (cnt == 6'd31) begin
          next_state = DivEnd;
        end else begin
          next_state = DivOn;
        end
      end
      DivEnd: begin
        if (div_annul || div_start == DivStop) begin
          next_state = DivFree;
        end else begin
          next_state = DivEnd;
        end
      end
      default: next_state = DivFree;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= 6'd0;
      acc           <= 65'd0;
      divisor_mag   <= 32'd0;
      sign_dividend <= 1'b0;
      sign_divisor  <= 1'b0;
      div_result    <= 64'd0;
      div_ready     <= DivResultNotReady;
    end else begin
      case (state)
        DivFree: begin
          div_ready <= DivResultNotReady;
          if (accept) begin
            cnt           <= 6'd0;
            sign_dividend <= div_signed & div_opdata1[31];
            sign_divisor  <= div_signed & div_opdata2[31];
            acc           <= {33'd0, abs_if(div_signed & div_opdata1[31], div_opdata1)};
            divisor_mag   <= abs_if(div_signed & div_opdata2[31], div_opdata2);
          end
        end
        DivByZero: begin
          div_ready <= DivResultNotReady;
`ifdef DIV_ZERO_EARLY_OUT_EN
          // acc[31:0] still holds |dividend|; restore its sign for the remainder.
          if (!div_annul) begin
            acc <= {1'b0, abs_if(sign_dividend, acc[31:0]),
                    sign_dividend ? 32'h0000_0001 : 32'hFFFF_FFFF};
          end
`endif
        end
        DivOn: begin
          div_ready <= DivResultNotReady;
          if (!div_annul) begin
            acc <= (cnt == 6'd31) ? acc_final : step_out;
            cnt <= cnt + 6'd1;
          end
        end
        DivEnd: begin
          if (!div_annul && div_start == DivStart) begin
            div_result <= acc[63:0];
            div_ready  <= DivResultReady;
          end else begin
            div_ready  <= DivResultNotReady;
          end
        end
        default: div_ready <= DivResultNotReady;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operands
// checked against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_opdata1;
  logic [31:0] div_opdata2;
  logic        div_annul;
  logic [63:0] div_result;
  logic        div_ready;
  logic        stallreq_for_div;

  int n_checks = 0;
  int n_fails  = 0;

  div_unit dut (
    .clk              (clk),
    .rst              (rst),
    .div_start        (div_start),
    .div_signed       (div_signed),
    .div_opdata1      (div_opdata1),
    .div_opdata2      (div_opdata2),
    .div_annul        (div_annul),
    .div_result       (div_result),
    .div_ready        (div_ready),
    .stallreq_for_div (stallreq_for_div)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; divisor 0 yields all-ones magnitude quotient.
  task automatic ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      q = (sg && a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
      r = a;
    end else begin
      if (sg) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      lq = sa / sb;
      lr = sa % sb;
      q  = 32'(lq);
      r  = 32'(lr);
    end
  endtask

  function automatic int exp_latency(input logic [31:0] b);
`ifdef DIV_ZERO_EARLY_OUT_EN
    return (b == 32'd0) ? 2 : 33;
`else
    return (b == 32'd0) ? 33 : 33;
`endif
  endfunction

  // Runs one division; leaves div_start high with div_ready asserted on return.
  task automatic run_div(input string tag, input logic sg, input logic [31:0] a,
                         input logic [31:0] b);
    logic [31:0] q, r;
    int lat, stall_cnt;
    ref_div(sg, a, b, q, r);
    @(negedge clk);
    div_start   = 1'b1;
    div_signed  = sg;
    div_opdata1 = a;
    div_opdata2 = b;
    @(posedge clk);
    #1;
    div_opdata1 = $urandom;
    div_opdata2 = $urandom;
    div_signed  = ~sg;
    lat = 0;
    stall_cnt = 0;
    while (!div_ready && lat < 100) begin
      if (stallreq_for_div) stall_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_latency(b)));
    chk({tag, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_latency(b)));
    chk({tag, "_stall_drop"}, 64'(stallreq_for_div), 64'd0);
    chk({tag, "_result"}, div_result, {r, q});
  endtask

  task automatic release_start(input string tag);
    @(negedge clk);
    div_start = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_ready_low"}, 64'(div_ready), 64'd0);
  endtask

  initial begin
    logic [63:0] prev;
    logic [31:0] ra, rb;
    logic        rs;
    int          waited;

    rst = 1'b1;
    div_start = 1'b0;
    div_signed = 1'b0;
    div_opdata1 = 32'd0;
    div_opdata2 = 32'd0;
    div_annul = 1'b0;
    #12;
    chk("reset_result", div_result, 64'd0);
    chk("reset_ready", 64'(div_ready), 64'd0);
    chk("reset_stall", 64'(stallreq_for_div), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7);
    chk("divu_100_7_const", div_result, {32'h0000_0002, 32'h0000_000E});
    // Hold start past ready: result must stay valid and no new run begins.
    prev = div_result;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("hold_ready", 64'(div_ready), 64'd1);
      chk("hold_result", div_result, prev);
    end
    release_start("hold");

    run_div("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7);
    chk("div_m100_7_const", div_result, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
    release_start("m100");

    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_const", div_result, {32'h0000_0000, 32'h8000_0000});
    release_start("ovf");

    run_div("divu_5_0", 1'b0, 32'd5, 32'd0);
    chk("divu_5_0_const", div_result, {32'h0000_0005, 32'hFFFF_FFFF});
    release_start("z1");

    run_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0);
    chk("div_m5_0_const", div_result, {32'hFFFF_FFFB, 32'h0000_0001});
    release_start("z2");

    // Annul at ON cycle 10: no ready, prior result retained.
    prev = div_result;
    @(negedge clk);
    div_start = 1'b1;
    div_signed = 1'b0;
    div_opdata1 = 32'd1000;
    div_opdata2 = 32'd3;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    div_annul = 1'b1;
    @(posedge clk);
    #1;
    div_annul = 1'b0;
    div_start = 1'b0;
    chk("annul_ready", 64'(div_ready), 64'd0);
    waited = 0;
    while (!div_ready && waited < 40) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk("annul_never_ready", 64'(div_ready), 64'd0);
    chk("annul_result_kept", div_result, prev);
    run_div("after_annul", 1'b0, 32'd1000, 32'd3);
    release_start("annul");

    // Async reset mid-division clears outputs immediately.
    @(negedge clk);
    div_start = 1'b1;
    div_signed = 1'b1;
    div_opdata1 = 32'd77;
    div_opdata2 = 32'd5;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2;
    div_start = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_result", div_result, 64'd0);
    chk("rst_mid_ready", 64'(div_ready), 64'd0);
    chk("rst_mid_stall", 64'(stallreq_for_div), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    waited = 0;
    while (!div_ready && waited < 40) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk("rst_no_ready", 64'(div_ready), 64'd0);

    run_div("after_rst", 1'b1, 32'hFFFF_FFB3, 32'd5);
    release_start("after_rst");

    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case (i % 6)
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = $urandom & 32'h0000_FFFF;
        3: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      run_div("random", rs, ra, rb);
      release_start("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for the EX stage. It serves DIV/DIVU and produces the {remainder, quotient} pair that EX forwards as hi_i/lo_i on its HI/LO bus toward MEM, together with the HI/LO write enables. While a division is in flight it raises a stall request so the pipeline controller holds IF/ID/EX and inserts bubbles into MEM.

## Interface
Parameters: none (widths fixed at 32/64).
- clk  input  1  pipeline clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- div_start  input  1  level request from EX; held high until div_ready is seen
- div_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
- div_opdata1  input  32  dividend; sampled when start accepted
- div_opdata2  input  32  divisor; sampled when start accepted
- div_annul  input  1  abort in-flight division (EX flush)
- div_result  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}
- div_ready  output  1  result valid
- stallreq_for_div  output  1  = div_start & ~div_ready (combinational)

## Operation
- States: FREE, BYZERO (only with macro), ON, END.
- FREE: when div_start & ~div_annul, latch operands, signed flag and sign bits. Convert operands to magnitudes when signed. Clear the 6-bit counter. Go to ON, or to BYZERO when the divisor is 0 and the macro is enabled. Otherwise stay in FREE.
- ON: restoring radix-2 step per cycle on a 65-bit {rem, quo} register:
  - shift left 1;
  - trial = rem[64:32] - {1'b0, |divisor|};
  - if the trial is non-negative, rem <= trial and the quotient LSB is 1.
  - After the 32nd step (counter == 31), correct signs: negate the quotient if the operand signs differ; give the remainder the dividend's sign. Go to END.
- BYZERO: load the closed-form result q = (signed & dividend[31]) ? 32'h1 : 32'hFFFF_FFFF, r = dividend. Go to END. This equals what ON computes for divisor 0.
- END: div_ready = 1 and div_result valid. Stay while div_start = 1; return to FREE when div_start = 0. No restart without a start-low cycle.
- div_annul in ON or BYZERO: next state FREE, div_ready stays 0, partial result discarded. In END: return to FREE. In FREE: blocks acceptance.
- Arithmetic: magnitude of 0x8000_0000 is 0x8000_0000 treated as unsigned. Signed overflow 0x8000_0000 / -1 gives q = 0x8000_0000, r = 0; it does not trap.

## Timing
- Reset (async): state FREE, counter 0, div_result 64'h0, div_ready 0, internal operand regs 0.
- div_result and div_ready are registered. div_result holds its last completed value until the next completion.
- Latency, start accepted at edge N: ON occupies N+1..N+32. div_ready is high after edge N+33.
- With the macro and divisor 0: div_ready is high after edge N+2.
- stallreq_for_div is high from the first cycle div_start is seen through the last cycle before div_ready. It drops in the same cycle div_ready rises.
- Operand changes after acceptance have no effect.
- Reset asserted mid-division clears everything immediately. No ready is produced.

## Configuration
- DIV_ZERO_EARLY_OUT_EN defined: the BYZERO state exists and divide-by-zero completes in 2 cycles.
- DIV_ZERO_EARLY_OUT_EN undefined: divide-by-zero runs the full 33-cycle ON path.
- Result values are identical in both builds; only latency differs.

## Structure
- lib/defines.vh gains:
  - state encodings DivFree, DivByZero, DivOn, DivEnd (2-bit);
  - DivResultReady / DivResultNotReady;
  - DivStart / DivStop.
- One combinational sub-module, div_step: one restoring iteration, 65-bit in and 65-bit out. The FSM, counter and sign correction stay in div_unit.
- EX instantiates div_unit. It drives w_hi_we/w_lo_we high and hi_i/lo_i from div_result in the cycle div_ready = 1.

## Test plan
- DIVU 100 / 7: q = 0x0000000E, r = 0x00000002. div_ready rises 33 cycles after acceptance. stallreq_for_div is high for exactly 33 cycles.
- DIV -100 / 7: q = 0xFFFFFFF2, r = 0xFFFFFFFE.
- DIV 0x8000_0000 / 0xFFFF_FFFF: q = 0x80000000, r = 0.
- Divisor 0:
  - DIVU 5 / 0: q = 0xFFFFFFFF, r = 5.
  - DIV -5 / 0: q = 0x00000001, r = 0xFFFFFFFB.
  - Latency is 2 cycles with DIV_ZERO_EARLY_OUT_EN, 33 without.
- div_annul asserted at ON cycle 10: FREE on the next cycle, div_ready never rises, div_result keeps its prior value. A new start is then accepted and computed correctly.
- div_start held 3 cycles past div_ready: div_ready stays 1 and no second division begins. Start low for one cycle, then high with new operands: a fresh 33-cycle division runs. Async rst pulse mid-ON: all outputs 0 immediately.
